cr_wr_sched: RTL and testbench

- Round-robin write scheduler for the single 32-bit condition register write port (wr/wd).
- Sits between the CR producers (record-form ALU CR0 update, compare unit, CR logical unit, mtcrf/mcrf) and the CR storage.
- Each producer requests a field-masked update. The block arbitrates, merges the masked data onto the current CR value, and drives one registered full-width write per cycle.
- Exports a busy field mask for hazard and bypass logic.

---
 rtl/cr_wr_sched.sv | 129 ++++++++++++
 tb/tb_cr_wr_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_wr_sched.sv
// Round-robin, field-masked write scheduler for the 32-bit condition register.
// Build option: define CR_WR_MERGE_EN to fold disjoint-mask requests into the same write.
module cr_wr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_fmask,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic [31:0]          cr_rd,
  output logic                 cr_wr,
  output logic [31:0]          cr_wd,
  output logic [7:0]           busy_fmask
);

  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

  // Requester k is the big-endian slice k, i.e. the k-th group counted from the MSB.
  logic        vld [NREQ];
  logic [7:0]  fm  [NREQ];
  logic [31:0] dat [NREQ];

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             cr_wr_q, cr_wr_d;
  logic [31:0]      cr_wd_q, cr_wd_d;
  logic [7:0]       busy_q, busy_d;

  logic             found, grant_any;
  logic [PTR_W-1:0] prim, idx;
  logic [NREQ-1:0]  gnt;
  logic [7:0]       acc_f;
  logic [31:0]      mu, du, base;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W:0]   b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + b;
    if (s >= NREQ_W) s = s - NREQ_W;
    return s[PTR_W-1:0];
  endfunction

  // Field i (big-endian) is CR bits 4i..4i+3, so little-endian mask bit j covers bits 4j+3:4j.
  function automatic logic [31:0] expand(input logic [7:0] f);
    logic [31:0] m;
    m = '0;
    for (int unsigned j = 0; j < 8; j++) m[4*j +: 4] = {4{f[j]}};
    return m;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      vld[k] = req_valid[NREQ-1-k];
      fm[k]  = req_fmask[8*(NREQ-1-k) +: 8];
      dat[k] = req_data[32*(NREQ-1-k) +: 32];
    end
  end

  always_comb begin
    found = 1'b0;
    prim  = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = wrap_add(ptr_q, (PTR_W+1)'(off));
      if (!found && vld[idx]) begin
        found = 1'b1;
        prim  = idx;
      end
    end
    grant_any = found & ~stall;
    gnt   = '0;
    acc_f = '0;
    if (grant_any) begin
      gnt[prim] = 1'b1;
      acc_f     = fm[prim];
    end
`ifdef CR_WR_MERGE_EN
    if (grant_any) begin
      for (int unsigned off = 1; off < NREQ; off++) begin
        idx = wrap_add(prim, (PTR_W+1)'(off));
        if (vld[idx] && ((fm[idx] & acc_f) == 8'h00)) begin
          gnt[idx] = 1'b1;
          acc_f    = acc_f | fm[idx];
        end
      end
    end
`endif
  end

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) req_ready[NREQ-1-k] = gnt[k];
  end

  // A pending write lands this cycle, so cr_rd is stale and the merge base is cr_wd.
  always_comb begin
    mu = expand(acc_f);
    du = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k]) du = du | (dat[k] & expand(fm[k]));
    end
    base    = cr_wr_q ? cr_wd_q : cr_rd;
    cr_wr_d = grant_any & (acc_f != 8'h00);
    cr_wd_d = cr_wr_d ? ((base & ~mu) | (du & mu)) : cr_wd_q;
    busy_d  = cr_wr_d ? acc_f : '0;
    ptr_d   = grant_any ? wrap_add(prim, (PTR_W+1)'(1)) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cr_wr_q <= 1'b0;
      cr_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cr_wr_q <= cr_wr_d;
      cr_wd_q <= cr_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign cr_wr      = cr_wr_q;
  assign cr_wd      = cr_wd_q;
  assign busy_fmask = busy_q;

endmodule

// File: tb/tb_cr_wr_sched.sv
// Directed self-checking bench for cr_wr_sched (NREQ=4); merge expectations follow CR_WR_MERGE_EN.
module tb_cr_wr_sched;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic [3:0]   req_valid;
  logic [31:0]  req_fmask;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  cr_rd;
  logic         cr_wr;
  logic [31:0]  cr_wd;
  logic [7:0]   busy_fmask;

  int n_assert = 0;
  int n_fail   = 0;

  cr_wr_sched #(.NREQ(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_fmask  (req_fmask),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cr_rd      (cr_rd),
    .cr_wr      (cr_wr),
    .cr_wd      (cr_wd),
    .busy_fmask (busy_fmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester k sits in the big-endian slice k (bit 3 of req_valid is requester 0).
  task automatic set_req(input int k, input logic v, input logic [7:0] f, input logic [31:0] d);
    req_valid[3-k]          = v;
    req_fmask[8*(3-k) +: 8]  = f;
    req_data[32*(3-k) +: 32] = d;
  endtask

  task automatic clr_reqs;
    req_valid = '0;
    req_fmask = '0;
    req_data  = '0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    cr_rd = '0;
    clr_reqs();
    tick();
    tick();
    check("reset_wr",    32'(cr_wr), 32'h0);
    check("reset_wd",    cr_wd, 32'h0);
    check("reset_busy",  32'(busy_fmask), 32'h0);
    check("reset_ready", 32'(req_ready), 32'h0);

    // Single request
    rst_n = 1'b1;
    cr_rd = 32'h0123_4567;
    set_req(0, 1'b1, 8'h80, 32'hA000_0000);
    #1;
    check("single_ready", 32'(req_ready), 32'h8);
    tick();
    clr_reqs();
    #1;
    check("single_wr",   32'(cr_wr), 32'h1);
    check("single_wd",   cr_wd, 32'hA123_4567);
    check("single_busy", 32'(busy_fmask), 32'h80);
    check("idle_ready",  32'(req_ready), 32'h0);
    tick();
    check("idle_wr",   32'(cr_wr), 32'h0);
    check("idle_wd",   cr_wd, 32'hA123_4567);
    check("idle_busy", 32'(busy_fmask), 32'h0);

    // Reset mid-write (pointer is now 1)
    set_req(1, 1'b1, 8'h40, 32'h0500_0000);
    #1;
    check("rr_ptr1_ready", 32'(req_ready), 32'h4);
    tick();
    clr_reqs();
    check("pre_rst_wr", 32'(cr_wr), 32'h1);
    check("pre_rst_wd", cr_wd, 32'h0523_4567);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_wr",   32'(cr_wr), 32'h0);
    check("midrst_wd",   cr_wd, 32'h0);
    check("midrst_busy", 32'(busy_fmask), 32'h0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'h01, 32'h0);
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h8);

    // Conflict fairness: req0 and req1 on the same field alternate
    clr_reqs();
    set_req(0, 1'b1, 8'h01, 32'h0000_000A);
    set_req(1, 1'b1, 8'h01, 32'h0000_000B);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("fair_ready", 32'(req_ready), ((i % 2) == 0) ? 32'h8 : 32'h4);
      tick();
      check("fair_wd", cr_wd, ((i % 2) == 0) ? 32'h0123_456A : 32'h0123_456B);
    end
    clr_reqs();
    tick();

    // Merge of disjoint fields, pointer reset to 0
    pulse_reset();
    cr_rd = '0;
    set_req(0, 1'b1, 8'h80, 32'hF000_0000);
    set_req(2, 1'b1, 8'h01, 32'h0000_000F);
    #1;
`ifdef CR_WR_MERGE_EN
    check("merge_ready", 32'(req_ready), 32'hA);
    tick();
    clr_reqs();
    check("merge_wd",   cr_wd, 32'hF000_000F);
    check("merge_busy", 32'(busy_fmask), 32'h81);
`else
    check("merge_ready0", 32'(req_ready), 32'h8);
    tick();
    set_req(0, 1'b0, 8'h00, 32'h0);
    check("merge_wd0",   cr_wd, 32'hF000_0000);
    check("merge_busy0", 32'(busy_fmask), 32'h80);
    #1;
    check("merge_ready2", 32'(req_ready), 32'h2);
    tick();
    clr_reqs();
    check("merge_wd1",   cr_wd, 32'hF000_000F);
    check("merge_busy1", 32'(busy_fmask), 32'h01);
`endif
    tick();
    check("merge_idle_wr", 32'(cr_wr), 32'h0);

    // Back-to-back: cr_rd stays stale at 0
    cr_rd = '0;
    set_req(1, 1'b1, 8'h40, 32'h0500_0000);
    #1;
    check("b2b_ready0", 32'(req_ready), 32'h4);
    tick();
    set_req(1, 1'b1, 8'h20, 32'h0070_0000);
    check("b2b_wd0", cr_wd, 32'h0500_0000);
    #1;
    check("b2b_ready1", 32'(req_ready), 32'h4);
    tick();
    clr_reqs();
    check("b2b_wd1",   cr_wd, 32'h0570_0000);
    check("b2b_busy1", 32'(busy_fmask), 32'h20);
    tick();
    check("b2b_hold_wd", cr_wd, 32'h0570_0000);
    check("b2b_idle_wr", 32'(cr_wr), 32'h0);

    // Stall: in-flight write completes, pointer (1) holds
    set_req(0, 1'b1, 8'h10, 32'h0008_0000);
    #1;
    check("stall_pre_ready", 32'(req_ready), 32'h8);
    tick();
    clr_reqs();
    stall = 1'b1;
    set_req(1, 1'b1, 8'h08, 32'h0000_A000);
    set_req(2, 1'b1, 8'h04, 32'h0000_0B00);
    #1;
    check("stall_ready", 32'(req_ready), 32'h0);
    check("stall_inflight_wr", 32'(cr_wr), 32'h1);
    check("stall_inflight_wd", cr_wd, 32'h0008_0000);
    tick();
    tick();
    check("stall_wr",    32'(cr_wr), 32'h0);
    check("stall_hold",  cr_wd, 32'h0008_0000);
    check("stall_ready2", 32'(req_ready), 32'h0);
    stall = 1'b0;
    #1;
`ifdef CR_WR_MERGE_EN
    check("release_ready", 32'(req_ready), 32'h6);
    tick();
    check("release_wd",   cr_wd, 32'h0000_AB00);
    check("release_busy", 32'(busy_fmask), 32'h0C);
`else
    check("release_ready", 32'(req_ready), 32'h4);
    tick();
    check("release_wd",   cr_wd, 32'h0000_A000);
    check("release_busy", 32'(busy_fmask), 32'h08);
`endif

    // Zero-mask request is accepted but produces no write
    clr_reqs();
    set_req(0, 1'b1, 8'h00, 32'hFFFF_FFFF);
    #1;
    check("zmask_ready", 32'(req_ready), 32'h8);
    tick();
    clr_reqs();
    check("zmask_wr",   32'(cr_wr), 32'h0);
    check("zmask_busy", 32'(busy_fmask), 32'h0);
`ifdef CR_WR_MERGE_EN
    check("zmask_hold", cr_wd, 32'h0000_AB00);
`else
    check("zmask_hold", cr_wd, 32'h0000_A000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
